// File: rtl/mux_scan_sel_pkg.sv
// Purpose: shared types and constants for the mux_scan_sel selector.
//   state_t     : controller state encoding (IDLE / MANUAL / SCAN)
//   MODE_*      : values of the mode input
//   div_width() : divider counter width, at least one bit
package mux_scan_sel_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MANUAL = 2'd1,
      ST_SCAN   = 2'd2
   } state_t;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // A DIV of 1 still needs a one-bit counter to keep the logic well formed.
   function automatic int unsigned div_width(input int unsigned div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/mux_scan_sel_scan_counter.sv
// Purpose: dwell divider plus modulo-N channel counter for mux_scan_sel.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : clear the divider (entering scan)
//   step_en   : let the divider run and advance the channel on terminal count
//   ld, ld_val: load a channel index; indices >= N are ignored
//   ch        : registered channel index
//   ch_next   : value ch takes on the coming edge
//   wrap      : registered pulse, high the cycle after ch steps N-1 -> 0
module scan_counter
   import mux_scan_sel_pkg::*;
#(
   parameter int unsigned N     = 8,
   parameter int unsigned DIV   = 4,
   parameter int unsigned SEL_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             step_en,
   input  logic             ld,
   input  logic [SEL_W-1:0] ld_val,
   output logic [SEL_W-1:0] ch,
   output logic [SEL_W-1:0] ch_next,
   output logic             wrap
);

   localparam int unsigned      DIV_W    = div_width(DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(N - 1);

   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] w_div_next;
   logic [SEL_W-1:0] r_ch;
   logic             r_wrap;
   logic             w_wrap_next;
   logic             w_step;
   logic             w_ld_ok;

   // Extra bit on the compare so N == 2**SEL_W does not alias to zero.
   assign w_ld_ok = ld && ({1'b0, ld_val} < (SEL_W + 1)'(N));
   assign w_step  = step_en && (r_div == DIV_LAST);

   // Next divider / channel / wrap values.
   always_comb begin
      w_div_next  = r_div;
      ch_next     = r_ch;
      w_wrap_next = 1'b0;
      if (clr) begin
         w_div_next = '0;
      end else if (step_en) begin
         w_div_next = w_step ? '0 : r_div + DIV_W'(1);
      end
      if (w_ld_ok) begin
         ch_next = ld_val;
      end else if (w_step) begin
         if (r_ch == CH_LAST) begin
            ch_next     = '0;
            w_wrap_next = 1'b1;
         end else begin
            ch_next = r_ch + SEL_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_div  <= '0;
         r_ch   <= '0;
         r_wrap <= 1'b0;
      end else begin
         r_div  <= w_div_next;
         r_ch   <= ch_next;
         r_wrap <= w_wrap_next;
      end
   end

   assign ch   = r_ch;
   assign wrap = r_wrap;

endmodule

// File: rtl/mux_scan_sel.sv
// Purpose: registered N-channel, W-bit selector with manual and auto-scan modes.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   w        : flattened channel data, channel i at [i*W +: W]
//   sel, load: manual channel select and its capture strobe
//   mode     : 0 = manual, 1 = auto-scan
//   en       : block enable
//   f        : registered selected channel data
//   ch       : current channel index
//   valid    : high while f is being refreshed
//   wrap     : one-cycle pulse when the scan wraps to channel 0
module mux_scan_sel
   import mux_scan_sel_pkg::*;
#(
   parameter  int unsigned N     = 8,
   parameter  int unsigned W     = 4,
   parameter  int unsigned DIV   = 4,
   localparam int unsigned SEL_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N*W-1:0]   w,
   input  logic [SEL_W-1:0] sel,
   input  logic             load,
   input  logic             mode,
   input  logic             en,
   output logic [W-1:0]     f,
   output logic [SEL_W-1:0] ch,
   output logic             valid,
   output logic             wrap
);

   state_t           r_state;
   state_t           w_state_next;
   logic [W-1:0]     r_f;
   logic             r_valid;
   logic [W-1:0]     w_f_next;
   logic             w_valid_next;
   logic             w_clr;
   logic             w_step_en;
   logic             w_ld;
   logic [SEL_W-1:0] w_ch_next;
   logic [W-1:0]     w_ch_data;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state: en=0 always falls back to IDLE, otherwise mode picks the state.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (en) begin
               w_state_next = (mode == MODE_MANUAL) ? ST_MANUAL : ST_SCAN;
            end
         end
         ST_MANUAL, ST_SCAN: begin
            if (!en) begin
               w_state_next = ST_IDLE;
            end else begin
               w_state_next = (mode == MODE_MANUAL) ? ST_MANUAL : ST_SCAN;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Controls: f refreshes only while active and staying enabled.
   always_comb begin
      w_clr        = en && (mode == MODE_SCAN) && (r_state != ST_SCAN);
      w_step_en    = en && (mode == MODE_SCAN) && (r_state == ST_SCAN);
      w_ld         = en && load && (r_state == ST_MANUAL);
      w_valid_next = (w_state_next != ST_IDLE);
      w_f_next     = r_f;
      if (en && (r_state != ST_IDLE)) begin
         w_f_next = w_ch_data;
      end
   end

   // Channel slice; the counter never presents an index >= N.
   always_comb begin
      w_ch_data = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (w_ch_next == SEL_W'(i)) begin
            w_ch_data = w[i*W +: W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_f     <= '0;
         r_valid <= 1'b0;
      end else begin
         r_f     <= w_f_next;
         r_valid <= w_valid_next;
      end
   end

   scan_counter #(
      .N     (N),
      .DIV   (DIV),
      .SEL_W (SEL_W)
   ) u_scan_counter (
      .clk     (clk),
      .rst     (rst),
      .clr     (w_clr),
      .step_en (w_step_en),
      .ld      (w_ld),
      .ld_val  (sel),
      .ch      (ch),
      .ch_next (w_ch_next),
      .wrap    (wrap)
   );

   assign f     = r_f;
   assign valid = r_valid;

endmodule

// File: tb/tb_mux_scan_sel.sv
// Purpose: self-checking bench for mux_scan_sel; an N=8 and an N=5 instance
// share all control inputs and are compared against a behavioural model.
module tb_mux_scan_sel;

   localparam int unsigned DIV = 4;

   logic        clk;
   logic        rst;
   logic [31:0] w8;
   logic [19:0] w5;
   logic [2:0]  sel;
   logic        load;
   logic        mode;
   logic        en;

   logic [3:0]  f8,  f5;
   logic [2:0]  ch8, ch5;
   logic        valid8, valid5, wrap8, wrap5;
   logic [8:0]  act8, act5;

   assign w5   = w8[19:0];
   assign act8 = {f8, ch8, valid8, wrap8};
   assign act5 = {f5, ch5, valid5, wrap5};

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: 0 idle, 1 manual, 2 scan; m_dw = cycles spent on current channel.
   int         m_st [2];
   int         m_ch [2];
   int         m_dw [2];
   logic [3:0] m_f  [2];
   logic       m_valid [2];
   logic       m_wrap  [2];

   mux_scan_sel #(.N(8), .W(4), .DIV(DIV)) u_dut8 (
      .clk(clk), .rst(rst), .w(w8), .sel(sel), .load(load), .mode(mode), .en(en),
      .f(f8), .ch(ch8), .valid(valid8), .wrap(wrap8)
   );

   mux_scan_sel #(.N(5), .W(4), .DIV(DIV)) u_dut5 (
      .clk(clk), .rst(rst), .w(w5), .sel(sel), .load(load), .mode(mode), .en(en),
      .f(f5), .ch(ch5), .valid(valid5), .wrap(wrap5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] chan(input logic [31:0] d, input int c);
      return d[c*4 +: 4];
   endfunction

   function automatic logic [8:0] exp_vec(input int k);
      return {m_f[k], 3'(m_ch[k]), m_valid[k], m_wrap[k]};
   endfunction

   // Advance the model with the current inputs, then one clock edge.
   task automatic tick();
      for (int k = 0; k < 2; k++) begin
         int n;
         logic [31:0] d;
         n = (k == 0) ? 8 : 5;
         d = (k == 0) ? w8 : {12'd0, w8[19:0]};
         if (rst) begin
            m_st[k] = 0; m_ch[k] = 0; m_dw[k] = 0; m_f[k] = 4'h0; m_wrap[k] = 1'b0;
         end else begin
            m_wrap[k] = 1'b0;
            if (m_st[k] == 0) begin
               if (en) begin
                  m_st[k] = mode ? 2 : 1;
                  m_dw[k] = 0;
               end
            end else if (!en) begin
               m_st[k] = 0;
            end else if (m_st[k] == 1) begin
               if (load && int'(sel) < n) m_ch[k] = int'(sel);
               m_f[k] = chan(d, m_ch[k]);
               if (mode) begin
                  m_st[k] = 2;
                  m_dw[k] = 0;
               end
            end else begin
               if (!mode) begin
                  m_st[k] = 1;
               end else begin
                  m_dw[k]++;
                  if (m_dw[k] == DIV) begin
                     m_dw[k] = 0;
                     if (m_ch[k] == n - 1) begin
                        m_ch[k]   = 0;
                        m_wrap[k] = 1'b1;
                     end else begin
                        m_ch[k]++;
                     end
                  end
               end
               m_f[k] = chan(d, m_ch[k]);
            end
         end
         m_valid[k] = (m_st[k] != 0);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; sel = 3'd0; w8 = 32'h76543210;
      tick(); tick();
      rst = 1'b0;
      n_tests++;
      if (act8 !== 9'd0) begin
         n_fail++; $display("FAIL reset_zero dut8 act=%h exp=%h", act8, 9'd0);
      end
      n_tests++;
      if (act5 !== exp_vec(1)) begin
         n_fail++; $display("FAIL reset dut5 act=%h exp=%h", act5, exp_vec(1));
      end
      tick();
      n_tests++;
      if (act8 !== exp_vec(0)) begin
         n_fail++; $display("FAIL reset_idle dut8 act=%h exp=%h", act8, exp_vec(0));
      end
   endtask

   task automatic test_manual();
      w8 = 32'h76543210; en = 1'b1; mode = 1'b0;
      tick();
      n_tests++;
      if (act8 !== exp_vec(0)) begin
         n_fail++; $display("FAIL manual_enter dut8 act=%h exp=%h", act8, exp_vec(0));
      end
      load = 1'b1; sel = 3'd5;
      tick();
      load = 1'b0;
      n_tests++;
      if (f8 !== 4'h5 || ch8 !== 3'd5 || valid8 !== 1'b1) begin
         n_fail++; $display("FAIL manual_sel5 f=%h ch=%0d v=%b exp f=5 ch=5 v=1", f8, ch8, valid8);
      end
      n_tests++;
      if (act5 !== exp_vec(1)) begin
         n_fail++; $display("FAIL manual_sel5 dut5 act=%h exp=%h", act5, exp_vec(1));
      end
      w8[23:20] = 4'hA;
      tick();
      n_tests++;
      if (f8 !== 4'hA || act8 !== exp_vec(0)) begin
         n_fail++; $display("FAIL manual_live f=%h exp=a act=%h exp=%h", f8, act8, exp_vec(0));
      end
   endtask

   task automatic test_scan();
      int wraps8, wraps5;
      wraps8 = 0; wraps5 = 0;
      rst = 1'b1; tick(); rst = 1'b0;
      en = 1'b1; mode = 1'b1;
      for (int c = 0; c < 33; c++) begin
         w8 = $urandom;
         tick();
         if (wrap8) wraps8++;
         if (wrap5) wraps5++;
         n_tests++;
         if (act8 !== exp_vec(0) || act5 !== exp_vec(1)) begin
            n_fail++;
            $display("FAIL scan cyc=%0d dut8 act=%h exp=%h dut5 act=%h exp=%h",
                     c, act8, exp_vec(0), act5, exp_vec(1));
         end
      end
      n_tests++;
      if (wraps8 != 1 || wraps5 != 1 || ch8 !== 3'd0) begin
         n_fail++; $display("FAIL scan_wrap wraps8=%0d wraps5=%0d ch8=%0d exp 1 1 0", wraps8, wraps5, ch8);
      end
   endtask

   task automatic test_out_of_range();
      logic [3:0] hold_f;
      rst = 1'b1; tick(); rst = 1'b0;
      w8 = $urandom; en = 1'b1; mode = 1'b0; load = 1'b0;
      tick();
      load = 1'b1; sel = 3'd2;
      tick();
      n_tests++;
      if (ch5 !== 3'd2 || act5 !== exp_vec(1)) begin
         n_fail++; $display("FAIL oor_sel2 ch5=%0d exp 2 act=%h exp=%h", ch5, act5, exp_vec(1));
      end
      hold_f = f5;
      sel = 3'd6;
      tick();
      n_tests++;
      if (ch5 !== 3'd2 || f5 !== hold_f) begin
         n_fail++; $display("FAIL oor_sel6 ch5=%0d f5=%h exp ch 2 f %h", ch5, f5, hold_f);
      end
      n_tests++;
      if (act8 !== exp_vec(0)) begin
         n_fail++; $display("FAIL oor_sel6 dut8 act=%h exp=%h", act8, exp_vec(0));
      end
      sel = 3'd4;
      tick();
      load = 1'b0;
      n_tests++;
      if (ch5 !== 3'd4 || act5 !== exp_vec(1)) begin
         n_fail++; $display("FAIL oor_sel4 ch5=%0d exp 4 act=%h exp=%h", ch5, act5, exp_vec(1));
      end
   endtask

   task automatic test_disable_resume();
      logic [3:0] hold_f;
      int dwell;
      rst = 1'b1; tick(); rst = 1'b0;
      en = 1'b1; mode = 1'b1;
      for (int c = 0; c < 14; c++) begin
         w8 = $urandom;
         tick();
      end
      n_tests++;
      if (ch8 !== 3'd3 || act8 !== exp_vec(0)) begin
         n_fail++; $display("FAIL dis_pre ch8=%0d exp 3 act=%h exp=%h", ch8, act8, exp_vec(0));
      end
      hold_f = f8;
      en = 1'b0;
      for (int c = 0; c < 3; c++) begin
         w8 = $urandom;
         tick();
         n_tests++;
         if (valid8 !== 1'b0 || ch8 !== 3'd3 || f8 !== hold_f || act5 !== exp_vec(1)) begin
            n_fail++;
            $display("FAIL dis_hold v=%b ch=%0d f=%h exp v=0 ch=3 f=%h dut5 act=%h exp=%h",
                     valid8, ch8, f8, hold_f, act5, exp_vec(1));
         end
      end
      en = 1'b1;
      dwell = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         n_tests++;
         if (act8 !== exp_vec(0)) begin
            n_fail++; $display("FAIL resume cyc=%0d act=%h exp=%h", c, act8, exp_vec(0));
         end
         if (ch8 !== 3'd3) break;
         dwell++;
      end
      n_tests++;
      if (dwell != 4) begin
         n_fail++; $display("FAIL resume_dwell got=%0d exp=4", dwell);
      end
   endtask

   task automatic test_reset_midscan();
      rst = 1'b1; tick(); rst = 1'b0;
      en = 1'b1; mode = 1'b1;
      for (int c = 0; c < 32; c++) begin
         w8 = $urandom;
         tick();
      end
      n_tests++;
      if (ch8 !== 3'd7 || act8 !== exp_vec(0)) begin
         n_fail++; $display("FAIL mid_pre ch8=%0d exp 7 act=%h exp=%h", ch8, act8, exp_vec(0));
      end
      rst = 1'b1;
      tick();
      n_tests++;
      if (act8 !== 9'd0 || act5 !== 9'd0) begin
         n_fail++; $display("FAIL mid_rst dut8 act=%h dut5 act=%h exp 000", act8, act5);
      end
      rst = 1'b0; en = 1'b0;
      tick();
      n_tests++;
      if (act8 !== 9'd0 || act8 !== exp_vec(0)) begin
         n_fail++; $display("FAIL mid_idle act=%h exp=%h", act8, exp_vec(0));
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst  = ($urandom_range(0, 49) == 0);
         en   = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 7) == 0) mode = ~mode;
         load = $urandom_range(0, 1) == 1;
         sel  = 3'($urandom);
         w8   = $urandom;
         tick();
         n_tests++;
         if (act8 !== exp_vec(0) || act5 !== exp_vec(1)) begin
            n_fail++;
            $display("FAIL random cyc=%0d dut8 act=%h exp=%h dut5 act=%h exp=%h",
                     c, act8, exp_vec(0), act5, exp_vec(1));
         end
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; sel = 3'd0; w8 = 32'h76543210;
      test_reset();
      test_manual();
      test_scan();
      test_out_of_range();
      test_disable_resume();
      test_reset_midscan();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_scan_sel.md
Name: mux_scan_sel

Overview:
- Registered, parametrised N-channel, W-bit selector. Successor to the combinational 8-to-1 selector.
- Adds a manual mode (latched select) and an auto-scan mode that steps through the channels every DIV cycles.
- Provides valid and wrap status outputs.
- Feeds display/time-multiplexed datapaths that need one channel presented at a time with a known one-cycle latency.

Parameters:
- N, 8, number of input channels (N >= 2; power of two not required).
- W, 4, bit width of each channel.
- DIV, 4, clock cycles each channel is held in scan mode (DIV >= 1).
- SEL_W, $clog2(N), derived select/channel width. Not overridden.

Ports:
- clk, input, 1, system clock. All state updates on rising edge.
- rst, input, 1, synchronous active-high reset. Sampled on rising edge of clk.
- w, input, N*W, flattened channel data. Channel i occupies bits [i*W +: W]; channel 0 at the LSBs.
- sel, input, SEL_W, manual channel select. Used only with load in MANUAL.
- load, input, 1, capture sel into the channel register (MANUAL only).
- mode, input, 1, 0 = manual, 1 = auto-scan.
- en, input, 1, block enable.
- f, output, W, registered selected channel data.
- ch, output, SEL_W, currently selected channel index.
- valid, output, 1, high while f is being refreshed (MANUAL or SCAN state).
- wrap, output, 1, one-cycle pulse when scan steps from channel N-1 to 0.

Behaviour:
- Reset is synchronous, active-high, and has highest priority. On reset: state=IDLE, f=0, ch=0, valid=0, wrap=0, divider count=0.
- There are three states: IDLE, MANUAL, SCAN.
- IDLE:
  - f, ch and the divider count hold; valid=0; wrap=0.
  - en=1 moves to MANUAL (mode=0) or SCAN (mode=1) on the next edge.
- MANUAL:
  - On load=1 with sel < N: ch <= sel.
  - On load=1 with sel >= N: ch holds (out-of-range select ignored).
  - f <= w[ch_next] every cycle, where ch_next is the value ch takes on the same edge. f therefore tracks live input with 1-cycle latency.
  - valid=1; wrap=0.
- SCAN:
  - The divider counts 0..DIV-1. When it reaches DIV-1, the divider clears and ch <= (ch == N-1) ? 0 : ch+1.
  - wrap=1 only on the cycle after ch steps N-1 -> 0.
  - f <= w[ch_next] every cycle; valid=1.
  - load is ignored.
  - DIV=1 advances ch every cycle.
- Mode change while en=1:
  - Takes effect on the next edge; ch is kept.
  - Entering SCAN clears the divider, so the current channel is held a full DIV cycles.
  - Entering MANUAL from SCAN clears wrap.
- en=0 in MANUAL or SCAN:
  - Next edge goes to IDLE; valid drops in that cycle; f and ch hold their last values.
  - Re-enabling resumes from the held ch.
- Width rules:
  - ch wraps explicitly at N-1, not at 2^SEL_W-1.
  - The divider width is $clog2(DIV) with a minimum of 1.
  - Indices >= N never reach the data path.
- Simultaneous events:
  - rst beats all other inputs.
  - en=0 beats load and mode.
  - In SCAN, the divider step and wrap are evaluated on the same edge.
- Reset mid-scan returns immediately to channel 0, f=0, with no wrap pulse.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, MANUAL=2'd1, SCAN=2'd2);
  - mode constants MODE_MANUAL=1'b0, MODE_SCAN=1'b1.
- One sub-module, scan_counter:
  - contains the DIV divider plus the modulo-N channel counter;
  - inputs: clk, rst, clr, step_en, ld, ld_val;
  - outputs: ch, ch_next, wrap.
- Top level holds the FSM, the output register and the channel slicing of w.

Test Plan:
1. Reset with N=8, W=4, w=32'h76543210: assert rst 2 cycles, then release -> f=0, ch=0, valid=0, wrap=0.
2. Manual select: en=1, mode=0, load=1, sel=5 for one cycle -> next edge ch=5, f=4'h5, valid=1. Change w channel 5 to 4'hA -> f=4'hA one cycle later.
3. Auto-scan: en=1, mode=1, DIV=4 -> ch steps 0,1,...,7,0 every 4 cycles, f equals the channel value throughout. wrap=1 for exactly one cycle, after 32 cycles.
4. Out-of-range select: N=5, MANUAL, load with sel=6 -> ch and f unchanged. sel=4 -> ch=4.
5. Disable and resume: in SCAN at ch=3, drop en for 3 cycles -> valid=0, ch=3 and f hold. Re-assert en -> SCAN resumes at ch=3 with a full 4-cycle dwell.
6. Reset mid-scan: rst pulsed while ch=7 on its last dwell cycle -> ch=0, f=0, no wrap pulse, state IDLE.
